// File: rtl/vga_scanout.sv
// -----------------------------------------------------------------------------
// vga_scanout
//
// Purpose
//   VGA timing generator and gray-level scanout. A programmable clock divider
//   produces one pixel tick every (pixel_div + 1) clocks. The pixel tick drives
//   the horizontal/vertical position counters. Every output is registered on a
//   tick edge from the position before the increment, so there is one tick of
//   latency. The exceptions are the two strobes, which last one clk.
//
// Optional feature
//   Define VGA_SCANOUT_TESTPAT_EN to add the test_pattern input. When that
//   input is latched high at frame start, gray_out shows h[GRAY_BITS-1:0] on
//   active pixels, and the framebuffer is not advanced.
//
// Ports
//   clk                   single clock
//   rst                   asynchronous active-high reset
//   pixel_div             clocks per pixel minus 1 (latched at frame start)
//   h_double              horizontal pixel doubling (latched at frame start)
//   frame_pixel_in        framebuffer data, sampled on active ticks
//   test_pattern          (VGA_SCANOUT_TESTPAT_EN only) test pattern select
//   h_sync_out            active-low horizontal sync
//   v_sync_out            active-low vertical sync
//   gray_out              pixel level, 0 outside the active area
//   frame_next_pixel_out  one-clk strobe: framebuffer advance
//   frame_reset_out       one-clk strobe: framebuffer rewind (held in reset)
// -----------------------------------------------------------------------------
module vga_scanout #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int GRAY_BITS = 4,
    parameter int DIV_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_BITS-1:0]  pixel_div,
    input  logic                 h_double,
    input  logic [GRAY_BITS-1:0] frame_pixel_in,
`ifdef VGA_SCANOUT_TESTPAT_EN
    input  logic                 test_pattern,
`endif
    output logic                 h_sync_out,
    output logic                 v_sync_out,
    output logic [GRAY_BITS-1:0] gray_out,
    output logic                 frame_next_pixel_out,
    output logic                 frame_reset_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    // The comparison constants are one bit wider than the counters. This
    // keeps a sync end equal to the total from overflowing the counter width.
    localparam logic [HW:0] H_ACT_X      = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0] H_SYN_BEG_X  = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0] H_SYN_END_X  = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW:0] H_LAST_X     = (HW+1)'(H_TOTAL - 1);
    localparam logic [VW:0] V_ACT_X      = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0] V_SYN_BEG_X  = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0] V_SYN_END_X  = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW:0] V_LAST_X     = (VW+1)'(V_TOTAL - 1);

    logic [DIV_BITS-1:0]  cnt_q, cnt_d;
    logic [DIV_BITS-1:0]  div_q, div_d;
    logic                 dbl_q, dbl_d;
    logic [HW-1:0]        h_q, h_d;
    logic [VW-1:0]        v_q, v_d;
    logic                 hs_q, hs_d;
    logic                 vs_q, vs_d;
    logic [GRAY_BITS-1:0] gray_q, gray_d;
    logic                 fnp_q, fnp_d;
    logic                 frst_q, frst_d;
    logic                 pend_q, pend_d;   // high from reset until the first tick

    logic                 at_origin;
    logic [DIV_BITS-1:0]  div_cur;
    logic                 dbl_cur;
    logic                 tp_cur;
    logic                 tick;
    logic                 active;
    logic                 advance;
    logic [HW:0]          h_x;
    logic [VW:0]          v_x;
    logic [GRAY_BITS-1:0] pix_src;

`ifdef VGA_SCANOUT_TESTPAT_EN
    logic                      tp_q, tp_d;
    logic [HW+GRAY_BITS-1:0]   h_ext;
`endif

    always_comb begin
        h_x       = {1'b0, h_q};
        v_x       = {1'b0, v_q};
        at_origin = (h_q == '0) && (v_q == '0);

        // At h=0, v=0 the live inputs drive the configuration. They are
        // captured on every clock spent at the origin. From the first pixel
        // onward the frame runs on the captured copy, so changes made
        // mid-frame are ignored. Reset forces the origin, so while reset is
        // held the effective configuration follows the inputs.
        div_cur = at_origin ? pixel_div : div_q;
        dbl_cur = at_origin ? h_double  : dbl_q;

`ifdef VGA_SCANOUT_TESTPAT_EN
        tp_cur  = at_origin ? test_pattern : tp_q;
        tp_d    = tp_cur;
        h_ext   = {{GRAY_BITS{1'b0}}, h_q};
        pix_src = tp_cur ? h_ext[GRAY_BITS-1:0] : frame_pixel_in;
`else
        tp_cur  = 1'b0;
        pix_src = frame_pixel_in;
`endif

        // Using >= rather than == stops a smaller pixel_div, applied while
        // sitting at the origin, from making the divider run past its limit.
        tick    = (cnt_q >= div_cur);
        active  = (h_x < H_ACT_X) && (v_x < V_ACT_X);
        advance = active && (!dbl_cur || !h_q[0]);

        cnt_d  = cnt_q + DIV_BITS'(1);
        div_d  = div_cur;
        dbl_d  = dbl_cur;
        h_d    = h_q;
        v_d    = v_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        gray_d = gray_q;
        fnp_d  = 1'b0;
        frst_d = pend_q;    // hold the reset-time rewind until the first tick
        pend_d = pend_q;

        if (tick) begin
            cnt_d  = '0;
            pend_d = 1'b0;

            if (h_x == H_LAST_X) begin
                h_d = '0;
                v_d = (v_x == V_LAST_X) ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end

            hs_d   = !((h_x >= H_SYN_BEG_X) && (h_x < H_SYN_END_X));
            vs_d   = !((v_x >= V_SYN_BEG_X) && (v_x < V_SYN_END_X));
            // Odd pixels in doubling mode keep the even pixel's level.
            gray_d = active ? (advance ? pix_src : gray_q) : '0;
            fnp_d  = advance && !tp_cur;
            frst_d = (h_q == '0) && (v_x == V_ACT_X);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= '0;
            dbl_q  <= 1'b0;
            h_q    <= '0;
            v_q    <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            gray_q <= '0;
            fnp_q  <= 1'b0;
            frst_q <= 1'b1;
            pend_q <= 1'b1;
`ifdef VGA_SCANOUT_TESTPAT_EN
            tp_q   <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            dbl_q  <= dbl_d;
            h_q    <= h_d;
            v_q    <= v_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            gray_q <= gray_d;
            fnp_q  <= fnp_d;
            frst_q <= frst_d;
            pend_q <= pend_d;
`ifdef VGA_SCANOUT_TESTPAT_EN
            tp_q   <= tp_d;
`endif
        end
    end

    assign h_sync_out           = hs_q;
    assign v_sync_out           = vs_q;
    assign gray_out             = gray_q;
    assign frame_next_pixel_out = fnp_q;
    assign frame_reset_out      = frst_q;

endmodule

// File: tb/tb_vga_scanout.sv
// -----------------------------------------------------------------------------
// tb_vga_scanout
//
// Test bench for a small raster: 4+1+1+1 = 7 pixels per line and
// 2+1+1+1 = 5 lines per frame, giving 35 pixel positions per frame.
//
// For each frame, the stimulus pushes the output events it expects into a
// queue. Each event carries a kind, the sample cycle and a gray level. A
// separate monitor samples the outputs 1 ns after every clock edge, turns
// them into events, and compares each one with the head of the queue.
//
// Event kinds:
//   0  frame_next_pixel_out pulse
//   1  frame_reset_out high
//   2  h_sync_out falls
//   3  v_sync_out falls
//   4  h_sync_out rises
//   5  v_sync_out rises
//   6  gray_out changes
// -----------------------------------------------------------------------------
module tb_vga_scanout;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pixel_div = 4'd0;
    logic       h_double = 1'b0;
    logic [3:0] frame_pixel_in = 4'd0;
`ifdef VGA_SCANOUT_TESTPAT_EN
    logic       test_pattern = 1'b0;
`endif
    logic       h_sync_out, v_sync_out, frame_next_pixel_out, frame_reset_out;
    logic [3:0] gray_out;

    vga_scanout #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .GRAY_BITS(4), .DIV_BITS(4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .pixel_div            (pixel_div),
        .h_double             (h_double),
        .frame_pixel_in       (frame_pixel_in),
`ifdef VGA_SCANOUT_TESTPAT_EN
        .test_pattern         (test_pattern),
`endif
        .h_sync_out           (h_sync_out),
        .v_sync_out           (v_sync_out),
        .gray_out             (gray_out),
        .frame_next_pixel_out (frame_next_pixel_out),
        .frame_reset_out      (frame_reset_out)
    );

    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] g;
    } ev_t;

    ev_t        evq[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         base = 0;
    bit         var_mode = 1'b0;
    logic [3:0] exp_g = 4'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel data driven after clock edge x and sampled at edge x+1.
    // In var_mode the data is never 0, and two values taken two cycles
    // apart always differ.
    function automatic logic [3:0] pix_at(input int x);
        if (var_mode) return 4'((x % 15) + 1);
        return 4'hA;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            frame_pixel_in = pix_at(cyc);
        end
    end

    task automatic push(input int k, input int c, input logic [3:0] g);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.g    = g;
        evq.push_back(e);
    endtask

    // Expected events for the first npos positions of a frame. Position n
    // (h = n%7, v = n/7) is registered on the tick at sample cycle
    // fbase + p*(n+1).
    //   - h_sync is low only for h = 5.
    //   - v_sync is low for v = 3, i.e. positions 21..27.
    //   - The rewind strobe fires at h = 0, v = 2 (position 14).
    //   - Active positions are h < 4 and v < 2.
    task automatic push_frame(input int fbase, input int p, input bit dbl,
                              input bit first, input int npos);
        if (first)
            for (int i = 1; i < p; i++) push(1, fbase + i, 4'd0);
        for (int n = 0; n < npos; n++) begin
            int         h;
            int         v;
            int         c;
            bit         act;
            bit         adv;
            logic [3:0] pix;
            logic [3:0] g;
            h   = n % 7;
            v   = n / 7;
            c   = fbase + p * (n + 1);
            pix = pix_at(c - 1);
            act = (h < 4) && (v < 2);
            adv = act && (!dbl || (h % 2 == 0));
            if (adv)              push(0, c, pix);
            if (h == 0 && v == 2) push(1, c, 4'd0);
            if (h == 5)           push(2, c, 4'd0);
            if (n == 21)          push(3, c, 4'd0);
            if (h == 6)           push(4, c, 4'd0);
            if (n == 28)          push(5, c, 4'd0);
            g = act ? (adv ? pix : exp_g) : 4'd0;
            if (g != exp_g) begin
                push(6, c, g);
                exp_g = g;
            end
        end
    endtask

    task automatic check_ev(input int k, input logic [3:0] g);
        ev_t e;
        total++;
        if (evq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_ev: got kind=%0d cyc=%0d gray=%h, required none",
                     k, cyc, g);
        end else begin
            e = evq[0];
            evq.delete(0);
            if (e.kind != k || e.cyc != cyc || e.g !== g) begin
                bad++;
                $display("FAIL ev: got kind=%0d cyc=%0d gray=%h, required kind=%0d cyc=%0d gray=%h",
                         k, cyc, g, e.kind, e.cyc, e.g);
            end else begin
                $display("ev ok: kind=%0d cyc=%0d gray=%h", k, cyc, g);
            end
        end
    endtask

    // Monitor
    initial begin
        logic       ph;
        logic       pv;
        logic [3:0] pg;
        ph = 1'b1;
        pv = 1'b1;
        pg = 4'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                while (evq.size() > 0 && evq[0].cyc < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL missing_ev: kind=%0d cyc=%0d gray=%h never seen (now cyc=%0d)",
                             evq[0].kind, evq[0].cyc, evq[0].g, cyc);
                    evq.delete(0);
                end
                if (frame_next_pixel_out)  check_ev(0, gray_out);
                if (frame_reset_out)       check_ev(1, 4'd0);
                if (ph && !h_sync_out)     check_ev(2, 4'd0);
                if (pv && !v_sync_out)     check_ev(3, 4'd0);
                if (!ph && h_sync_out)     check_ev(4, 4'd0);
                if (!pv && v_sync_out)     check_ev(5, 4'd0);
                if (gray_out !== pg)       check_ev(6, gray_out);
            end
            ph = h_sync_out;
            pv = v_sync_out;
            pg = gray_out;
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("chk ok: %s = %h", name, act);
        end
    endtask

    task automatic drain(input string name);
        total++;
        if (evq.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d expected events left, required 0", name, evq.size());
            evq.delete();
        end
    endtask

    // Called at a negedge. Reset is asserted between clock edges, so the
    // outputs must already be at their reset values 1 ns later.
    task automatic do_reset(input int div, input bit dbl, input bit vm);
        rst       = 1'b1;
        pixel_div = 4'(div);
        h_double  = dbl;
        var_mode  = vm;
        #1;
        chk("rst_hsync", {3'b0, h_sync_out},           4'd1);
        chk("rst_vsync", {3'b0, v_sync_out},           4'd1);
        chk("rst_gray",  gray_out,                     4'd0);
        chk("rst_fnp",   {3'b0, frame_next_pixel_out}, 4'd0);
        chk("rst_frst",  {3'b0, frame_reset_out},      4'd1);
        repeat (3) @(negedge clk);
        exp_g = 4'd0;
        rst   = 1'b0;
        base  = cyc;
    endtask

    task automatic run_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);

        // Divider 0, constant data: two full frames back to back.
        do_reset(0, 0, 0);
        push_frame(base, 1, 0, 1, 35);
        push_frame(base + 35, 1, 0, 0, 35);
        run_until(base + 70);
        drain("div0");

        // Divider 2 (105-clk frame). Dropping to 0 mid-frame takes effect
        // only from the next frame origin.
        do_reset(2, 0, 0);
        push_frame(base, 3, 0, 1, 35);
        push_frame(base + 105, 1, 0, 0, 35);
        run_until(base + 50);
        pixel_div = 4'd0;
        run_until(base + 140);
        drain("div2");

        // Pixel doubling with data that changes every clock.
        do_reset(0, 1, 1);
        push_frame(base, 1, 1, 1, 35);
        run_until(base + 35);
        drain("dbl");

        // Reset at v=1, h=2 aborts the frame. The next frame restarts at the
        // origin.
        do_reset(0, 0, 0);
        push_frame(base, 1, 0, 1, 10);
        run_until(base + 10);
        drain("pre_abort");
        do_reset(0, 0, 0);
        push_frame(base, 1, 0, 1, 35);
        run_until(base + 35);
        drain("post_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 The module SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 The module SHALL have parameters H_FP, H_SYNC and H_BP, defaults 16, 96 and 48, meaning the horizontal front porch, sync and back porch in pixels.
REQ-003 The module SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-004 The module SHALL have parameters V_FP, V_SYNC and V_BP, defaults 10, 2 and 33, meaning the vertical front porch, sync and back porch in lines.
REQ-005 The module SHALL have parameter GRAY_BITS, default 4, meaning the gray-level width.
REQ-006 The module SHALL have parameter DIV_BITS, default 4, meaning the pixel-divider width.
REQ-007 The module SHALL have one clock and an asynchronous, active-high reset; polarity and synchronicity are fixed.
REQ-008 The ports SHALL be, in order:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- pixel_div  in  DIV_BITS  clocks per pixel minus 1.
- h_double  in  1  horizontal pixel-doubling mode.
- frame_pixel_in  in  GRAY_BITS  framebuffer data.
- test_pattern  in  1  present only with VGA_SCANOUT_TESTPAT_EN.
- h_sync_out  out  1  active-low horizontal sync.
- v_sync_out  out  1  active-low vertical sync.
- gray_out  out  GRAY_BITS  pixel level.
- frame_next_pixel_out  out  1  framebuffer advance strobe.
- frame_reset_out  out  1  framebuffer rewind strobe.

Function
REQ-009 The divider SHALL count 0..div_q and assert the internal signal tick when the count equals div_q.
REQ-010 pixel_div=0 SHALL produce a tick every clk.
REQ-011 div_q and the h_double mode SHALL be loaded from pixel_div and h_double only at the tick where h=0 and v=0, so mid-frame changes have no effect.
REQ-012 The counter h SHALL advance 0..H_TOTAL-1 on each tick, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-013 On h wrap, v SHALL advance 0..V_TOTAL-1 and then wrap to 0.
REQ-014 All outputs SHALL be registered and updated only on a tick edge, from the pre-increment h and v values, giving 1-tick latency.
REQ-015 h_sync_out SHALL be 0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
REQ-016 v_sync_out SHALL be 0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
REQ-017 Active SHALL mean h<H_ACTIVE and v<V_ACTIVE.
REQ-018 When active, gray_out SHALL be set to frame_pixel_in sampled at that tick edge; otherwise gray_out SHALL be 0.
REQ-019 frame_next_pixel_out SHALL be high for exactly one clk after each active tick.
REQ-020 With h_double mode set, frame_next_pixel_out SHALL pulse only on active ticks with even h, and gray_out SHALL hold its value for the odd h.
REQ-021 frame_reset_out SHALL be high for exactly one clk after the tick where h=0 and v=V_ACTIVE.
REQ-022 frame_next_pixel_out and frame_reset_out SHALL never be high in the same cycle.
REQ-023 Counter widths SHALL be $clog2(H_TOTAL) and $clog2(V_TOTAL), and no counter value at or above its total SHALL ever occur.

Reset
REQ-024 While rst=1, h, v and the divider count SHALL be 0.
REQ-025 While rst=1, div_q SHALL equal pixel_div and the latched h_double mode SHALL equal h_double.
REQ-026 While rst=1, h_sync_out and v_sync_out SHALL be 1, gray_out and frame_next_pixel_out SHALL be 0, and frame_reset_out SHALL be 1.
REQ-027 frame_reset_out SHALL clear on the first tick after rst deasserts.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, without completing the line.

Configuration
REQ-029 When the macro VGA_SCANOUT_TESTPAT_EN is defined and test_pattern=1 at frame start, gray_out SHALL be h[GRAY_BITS-1:0] when active and frame_next_pixel_out SHALL stay 0.
REQ-030 When VGA_SCANOUT_TESTPAT_EN is undefined, the test_pattern port and its logic SHALL be absent.

Verification
REQ-031 H_ACTIVE=4, H_FP=H_SYNC=H_BP=1, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1, pixel_div=0 -> h_sync_out low 1 clk every 7 clks, and v_sync_out low for 7 clks every 35 clks.
REQ-032 Same parameters, pixel_div=2 -> ticks every 3 clks, and a frame of 105 clks.
REQ-033 Changing pixel_div from 2 to 0 mid-frame -> the period is unchanged until the next h=0, v=0 tick.
REQ-034 frame_pixel_in=4'hA constant -> 8 frame_next_pixel_out pulses per frame, gray_out=A on active pixels and 0 elsewhere, and 1 frame_reset_out pulse.
REQ-035 h_double=1 with the same parameters -> 4 frame_next_pixel_out pulses per frame, each gray value held 2 pixels.
REQ-036 rst pulsed while v=1 -> all outputs take their reset values asynchronously, and the next frame restarts at h=0, v=0.
